// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the memory-port arbiter.
//   PORT_CPU / PORT_DBG : requester IDs carried through the response pipeline
//   ST_IDLE / ST_ISSUE  : arbiter FSM encoding
//   MEM_AW / MEM_DW     : memory address / data widths
//   mem_req_t           : payload of one memory access (we, addr, wdata)
package mem_pkg;

  localparam int unsigned MEM_AW = 8;
  localparam int unsigned MEM_DW = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two requester ports and the memory port.
//   slave  : arbiter side (takes requests and mem_from, drives grants/responses/memory bus)
//   master : environment side (requesters plus the memory itself)
interface mem_arbiter_if;

  logic                       p0_req;
  logic                       p0_we;
  logic [mem_pkg::MEM_AW-1:0] p0_addr;
  logic [mem_pkg::MEM_DW-1:0] p0_wdata;
  logic                       p0_gnt;
  logic                       p0_rvalid;
  logic [mem_pkg::MEM_DW-1:0] p0_rdata;

  logic                       p1_req;
  logic                       p1_we;
  logic [mem_pkg::MEM_AW-1:0] p1_addr;
  logic [mem_pkg::MEM_DW-1:0] p1_wdata;
  logic                       p1_gnt;
  logic                       p1_rvalid;
  logic [mem_pkg::MEM_DW-1:0] p1_rdata;

  logic [mem_pkg::MEM_AW-1:0] mem_address;
  logic [mem_pkg::MEM_DW-1:0] mem_to;
  logic                       mem_write;
  logic [mem_pkg::MEM_DW-1:0] mem_from;
  logic                       busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_from,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_address, mem_to, mem_write, busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_from,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_address, mem_to, mem_write, busy
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of consecutive port-0 wins against a waiting port 1.
//   clock, reset_n : clock and synchronous active-low reset
//   inc            : port 0 won while port 1 was requesting
//   clr            : port 1 won, or port 1 is not requesting
//   at_limit       : count has reached LIMIT (port 1 must win the next contention)
module arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  // At least 3 bits, wider only when LIMIT needs it.
  localparam int unsigned CW = (LIMIT < 8) ? 3 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Clear has priority over increment; the count never passes LIMIT.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(LIMIT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign at_limit = (cnt == CW'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 8-bit synchronous memory port between the CPU (port 0)
// and the debug/loader port (port 1), one access per cycle, with read data
// returned one cycle after issue.
//   clock, reset_n : clock and synchronous active-low reset
//   bus            : requester ports p0_*/p1_*, memory port mem_*, and busy
//   STARVE_LIMIT   : max consecutive port-0 wins while port 1 waits (0 = port 1 first)
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  logic       grant_p0;
  logic       grant_p1;
  logic       any_grant;
  logic       at_limit;
  logic       starve_inc;
  logic       starve_clr;
  logic       resp_capture;
  mem_req_t   sel_req;
  logic [0:0] state_q;
  logic [0:0] state_d;

  logic              p0_gnt_q;
  logic              p1_gnt_q;
  logic              p0_rvalid_q;
  logic              p1_rvalid_q;
  logic [MEM_DW-1:0] p0_rdata_q;
  logic [MEM_DW-1:0] p1_rdata_q;
  logic [MEM_AW-1:0] mem_address_q;
  logic [MEM_DW-1:0] mem_to_q;
  logic              mem_write_q;
  logic              resp_valid_q;
  logic              resp_port_q;

  // Grant selection and payload mux.
  always_comb begin
    grant_p0      = 1'b0;
    grant_p1      = 1'b0;
    sel_req       = '0;
    grant_p1      = bus.p1_req && (!bus.p0_req || at_limit);
    grant_p0      = bus.p0_req && !grant_p1;
    if (grant_p1) begin
      sel_req.we    = bus.p1_we;
      sel_req.addr  = bus.p1_addr;
      sel_req.wdata = bus.p1_wdata;
    end else begin
      sel_req.we    = bus.p0_we;
      sel_req.addr  = bus.p0_addr;
      sel_req.wdata = bus.p0_wdata;
    end
  end

  assign any_grant  = grant_p0 || grant_p1;
  assign starve_inc = grant_p0 && bus.p1_req;
  assign starve_clr = grant_p1 || !bus.p1_req;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock    (clock),
    .reset_n  (reset_n),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (at_limit)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: ISSUE for as long as accesses are granted back to back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_grant)  state_d = ST_ISSUE;
      ST_ISSUE: if (!any_grant) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A read issued last cycle has its data on mem_from now.
  assign resp_capture = (state_q == ST_ISSUE) && resp_valid_q;

  // Issue registers and response pipeline.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      p0_gnt_q      <= 1'b0;
      p1_gnt_q      <= 1'b0;
      p0_rvalid_q   <= 1'b0;
      p1_rvalid_q   <= 1'b0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
      mem_address_q <= '0;
      mem_to_q      <= '0;
      mem_write_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_port_q   <= PORT_CPU;
    end else begin
      p0_gnt_q     <= grant_p0;
      p1_gnt_q     <= grant_p1;
      mem_write_q  <= any_grant && sel_req.we;
      resp_valid_q <= any_grant && !sel_req.we;
      resp_port_q  <= grant_p1 ? PORT_DBG : PORT_CPU;
      // Address and data hold their last value on idle cycles.
      if (any_grant) begin
        mem_address_q <= sel_req.addr;
        mem_to_q      <= sel_req.wdata;
      end
      p0_rvalid_q <= resp_capture && (resp_port_q == PORT_CPU);
      p1_rvalid_q <= resp_capture && (resp_port_q == PORT_DBG);
      if (resp_capture && (resp_port_q == PORT_CPU)) p0_rdata_q <= bus.mem_from;
      if (resp_capture && (resp_port_q == PORT_DBG)) p1_rdata_q <= bus.mem_from;
    end
  end

  assign bus.p0_gnt      = p0_gnt_q;
  assign bus.p1_gnt      = p1_gnt_q;
  assign bus.p0_rvalid   = p0_rvalid_q;
  assign bus.p1_rvalid   = p1_rvalid_q;
  assign bus.p0_rdata    = p0_rdata_q;
  assign bus.p1_rdata    = p1_rdata_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_to      = mem_to_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.busy        = resp_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a read-response scoreboard.
// dut4 (STARVE_LIMIT=4) is fully checked; dut0 (STARVE_LIMIT=0) sees the same
// requests and only its contended grants are checked.
module tb_mem_arbiter;

  logic clock;
  logic reset_n;
  int unsigned cyc;
  int n_asserts;
  int n_fail;

  typedef struct {
    bit          port;
    logic [7:0]  data;
    int unsigned due;
  } sb_t;

  sb_t sb[$];

  mem_arbiter_if if4();
  mem_arbiter_if if0();

  mem_arbiter #(.STARVE_LIMIT(4)) dut4 (.clock(clock), .reset_n(reset_n), .bus(if4));
  mem_arbiter #(.STARVE_LIMIT(0)) dut0 (.clock(clock), .reset_n(reset_n), .bus(if0));

  assign if0.p0_req   = if4.p0_req;
  assign if0.p0_we    = if4.p0_we;
  assign if0.p0_addr  = if4.p0_addr;
  assign if0.p0_wdata = if4.p0_wdata;
  assign if0.p1_req   = if4.p1_req;
  assign if0.p1_we    = if4.p1_we;
  assign if0.p1_addr  = if4.p1_addr;
  assign if0.p1_wdata = if4.p1_wdata;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: combinational read, write committed at the edge ending the write cycle.
  logic [7:0] mem [256];

  function automatic logic [7:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 8'hA5;
    if (a < 8'd4) return 8'h11 * (a + 8'd1);
    return ~a;
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (if4.mem_write) begin
      mem[if4.mem_address] <= if4.mem_to;
    end
  end

  assign if4.mem_from = mem[if4.mem_address];
  assign if0.mem_from = mem[if0.mem_address];

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%02h expected=%02h", tag, cyc, obs, exp_v);
    end
  endtask

  // Per-cycle response check: rvalid must pulse exactly when a scoreboard entry is due.
  task automatic check_resp();
    logic exp_b;
    for (int p = 0; p < 2; p++) begin
      logic       exp_v;
      logic       obs_v;
      logic [7:0] obs_d;
      exp_v = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].port == (p == 1));
      obs_v = (p == 0) ? if4.p0_rvalid : if4.p1_rvalid;
      obs_d = (p == 0) ? if4.p0_rdata : if4.p1_rdata;
      chk1($sformatf("rvalid_p%0d", p), obs_v, exp_v);
      if (exp_v) begin
        if (obs_v) chk8($sformatf("rdata_p%0d", p), obs_d, sb[0].data);
        void'(sb.pop_front());
      end
    end
    exp_b = (sb.size() > 0) && (sb[sb.size()-1].due == cyc + 1);
    chk1("busy", if4.busy, exp_b);
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
    check_resp();
  endtask

  task automatic push(input bit port, input logic [7:0] data);
    sb_t e;
    e.port = port;
    e.data = data;
    e.due  = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic chk_gnt(input string tag, input logic e0, input logic e1);
    chk1({tag, "_p0_gnt"}, if4.p0_gnt, e0);
    chk1({tag, "_p1_gnt"}, if4.p1_gnt, e1);
  endtask

  task automatic all_zero(input string tag);
    chk_gnt(tag, 1'b0, 1'b0);
    chk1({tag, "_p0_rvalid"}, if4.p0_rvalid, 1'b0);
    chk1({tag, "_p1_rvalid"}, if4.p1_rvalid, 1'b0);
    chk8({tag, "_p0_rdata"}, if4.p0_rdata, 8'h00);
    chk8({tag, "_p1_rdata"}, if4.p1_rdata, 8'h00);
    chk8({tag, "_mem_address"}, if4.mem_address, 8'h00);
    chk8({tag, "_mem_to"}, if4.mem_to, 8'h00);
    chk1({tag, "_mem_write"}, if4.mem_write, 1'b0);
    chk1({tag, "_busy"}, if4.busy, 1'b0);
  endtask

  initial begin
    logic [7:0] seq_data [4];
    bit w1;
    seq_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    cyc = 0;
    n_asserts = 0;
    n_fail = 0;
    reset_n = 1'b0;
    if4.p0_req = 1'b0; if4.p0_we = 1'b0; if4.p0_addr = 8'h00; if4.p0_wdata = 8'h00;
    if4.p1_req = 1'b0; if4.p1_we = 1'b0; if4.p1_addr = 8'h00; if4.p1_wdata = 8'h00;

    // Reset state.
    tick();
    tick();
    all_zero("reset");

    // Single p0 read of 0x10 right after reset release.
    reset_n = 1'b1;
    if4.p0_req = 1'b1; if4.p0_addr = 8'h10;
    push(1'b0, 8'hA5);
    tick();
    chk_gnt("rd10", 1'b1, 1'b0);
    chk8("rd10_addr", if4.mem_address, 8'h10);
    chk1("rd10_we", if4.mem_write, 1'b0);
    if4.p0_req = 1'b0;
    tick();
    chk_gnt("rd10_after", 1'b0, 1'b0);
    chk8("rd10_p1_rdata", if4.p1_rdata, 8'h00);
    tick();

    // Back-to-back reads of 0x00..0x03.
    for (int i = 0; i < 4; i++) begin
      if4.p0_req = 1'b1; if4.p0_addr = 8'(i);
      push(1'b0, seq_data[i]);
      tick();
      chk_gnt($sformatf("b2b%0d", i), 1'b1, 1'b0);
      chk8($sformatf("b2b%0d_addr", i), if4.mem_address, 8'(i));
    end
    if4.p0_req = 1'b0;
    tick();
    chk_gnt("b2b_end", 1'b0, 1'b0);
    tick();

    // p1 writes 0x3C to 0x20, p0 reads it back the next cycle.
    if4.p1_req = 1'b1; if4.p1_we = 1'b1; if4.p1_addr = 8'h20; if4.p1_wdata = 8'h3C;
    tick();
    chk_gnt("wr", 1'b0, 1'b1);
    chk1("wr_strobe", if4.mem_write, 1'b1);
    chk8("wr_addr", if4.mem_address, 8'h20);
    chk8("wr_data", if4.mem_to, 8'h3C);
    if4.p1_req = 1'b0; if4.p1_we = 1'b0;
    if4.p0_req = 1'b1; if4.p0_we = 1'b0; if4.p0_addr = 8'h20;
    push(1'b0, 8'h3C);
    tick();
    chk_gnt("rbw", 1'b1, 1'b0);
    chk1("rbw_strobe_off", if4.mem_write, 1'b0);
    chk8("rbw_addr", if4.mem_address, 8'h20);
    if4.p0_req = 1'b0;
    tick();
    chk1("idle_strobe", if4.mem_write, 1'b0);
    chk8("idle_addr_hold", if4.mem_address, 8'h20);
    tick();

    // Continuous contention: p0 x4 then p1 (limit 4); always p1 (limit 0).
    if4.p0_req = 1'b1; if4.p0_addr = 8'h10;
    if4.p1_req = 1'b1; if4.p1_addr = 8'h01;
    for (int i = 0; i < 10; i++) begin
      w1 = (i % 5 == 4);
      push(w1, w1 ? 8'h22 : 8'hA5);
      tick();
      chk_gnt($sformatf("cont%0d", i), !w1, w1);
      chk1($sformatf("cont%0d_lim0_p0_gnt", i), if0.p0_gnt, 1'b0);
      chk1($sformatf("cont%0d_lim0_p1_gnt", i), if0.p1_gnt, 1'b1);
    end
    if4.p0_req = 1'b0; if4.p1_req = 1'b0;
    tick();
    tick();

    // One-cycle p1 blip under p0 priority: discarded, counter returns to 0.
    if4.p0_req = 1'b1; if4.p0_addr = 8'h10;
    if4.p1_req = 1'b1; if4.p1_addr = 8'h02;
    push(1'b0, 8'hA5);
    tick();
    chk_gnt("blip0", 1'b1, 1'b0);
    chk8("blip0_addr", if4.mem_address, 8'h10);
    if4.p1_req = 1'b0;
    push(1'b0, 8'hA5);
    tick();
    chk_gnt("blip1", 1'b1, 1'b0);
    chk8("blip1_addr", if4.mem_address, 8'h10);
    if4.p1_req = 1'b1; if4.p1_addr = 8'h01;
    for (int i = 0; i < 5; i++) begin
      w1 = (i == 4);
      push(w1, w1 ? 8'h22 : 8'hA5);
      tick();
      chk_gnt($sformatf("post_blip%0d", i), !w1, w1);
    end
    if4.p0_req = 1'b0; if4.p1_req = 1'b0;
    tick();
    tick();

    // Reset the cycle after a p1 read grant: response dropped, outputs cleared.
    if4.p1_req = 1'b1; if4.p1_addr = 8'h03;
    push(1'b1, 8'h44);
    tick();
    chk_gnt("rst_rd", 1'b0, 1'b1);
    if4.p1_req = 1'b0;
    reset_n = 1'b0;
    sb.delete();
    tick();
    all_zero("midrst");
    reset_n = 1'b1;
    if4.p1_req = 1'b1; if4.p1_addr = 8'h10;
    push(1'b1, 8'hA5);
    tick();
    chk_gnt("post_rst", 1'b0, 1'b1);
    chk8("post_rst_addr", if4.mem_address, 8'h10);
    if4.p1_req = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
